decoder_n_scan: RTL
===================

# decoder_n_scan

Registered, parametrised N-to-2^N one-hot decoder that extends the combinational 3-to-8 decoder with a clock, an asynchronous reset, a programmable output polarity and a self-stepping scan mode. In direct mode it decodes a loaded index. In scan mode it walks the one-hot output up or down at a programmable rate and flags each wrap-around. It sits wherever the design drives row/column selects, chip selects or time-multiplexed strobes from a single clock domain.

## Interface
Parameters:
- N, 3, select width; output width is 2^N (N ≥ 1)
- PERIOD, 1, clock cycles per scan step (≥ 1)
- ACTIVE_LOW, 0, 0: selected bit = 1, others 0; 1: selected bit = 0, others 1

Ports:
- clka  input  1  clock, all state on rising edge
- rst  input  1  reset; asynchronous, active-high
- E  input  1  enable; 0 forces Out inactive and freezes the index
- Mode  input  1  0: direct decode, 1: scan
- Dir  input  1  scan direction; 0: up, 1: down (ignored in direct mode)
- Load  input  1  load In into the index (both modes)
- In  input  N  index to load
- Out  output  2^N  registered one-hot (or one-cold) select
- Index  output  N  current index register
- Wrap  output  1  one-cycle pulse on scan wrap-around

## Operation
- State: idx (N bits), presc (counts 0..PERIOD-1), Out register, Wrap register.
- "inactive" = all zeros (ACTIVE_LOW=0) or all ones (ACTIVE_LOW=1). "onehot(k)" = bit k active, all other bits inactive.
- Per-edge priority, highest first:
  - E=0: idx holds, presc←0, Out←inactive, Wrap←0. Load is ignored.
  - E=1, Load=1 (either mode): idx←In, presc←0, Out←onehot(In), Wrap←0.
  - E=1, Mode=0: idx holds, presc←0, Out←onehot(idx), Wrap←0.
  - E=1, Mode=1, presc<PERIOD-1: presc←presc+1, idx holds, Out←onehot(idx), Wrap←0.
  - E=1, Mode=1, presc=PERIOD-1: presc←0; idx←idx+1 (Dir=0) or idx−1 (Dir=1), modulo 2^N; Out←onehot(new idx).
    - Wrap←1 only if the step is 2^N−1→0 (up) or 0→2^N−1 (down); otherwise Wrap←0.
- Effective states: IDLE (E=0), DIRECT (E=1, Mode=0), SCAN (E=1, Mode=1). Transitions follow the input levels every cycle.
- Mode changes:
  - SCAN→DIRECT keeps idx and clears presc.
  - DIRECT→SCAN starts counting from presc=0, so the first step lands PERIOD cycles later.
- A Dir change takes effect at the next step and does not reset presc.
- When E=1, Out always equals onehot(Index) on the same cycle; exactly one bit is active.
- PERIOD=1: presc is unused and idx steps every cycle in SCAN.

## Timing
- Reset (asynchronous assert, synchronous to clka on release): idx=0, presc=0, Index=0, Out=inactive, Wrap=0. First active edge after release applies the normal rules.
- Reset asserted mid-scan clears everything immediately, with no wait for clka.
- Latency: inputs sampled at edge k appear on Out/Index/Wrap immediately after edge k (1 cycle, registered). No combinational path from inputs to outputs.
- E rising: Out becomes onehot(idx), or onehot(In) if Load, one edge after E is sampled high.
- Scan rate: Index changes every PERIOD cycles of uninterrupted SCAN. A full cycle through all indices takes 2^N·PERIOD cycles with exactly one Wrap pulse.
- Load during SCAN on a step cycle: Load wins, no step, no Wrap.
- Wrap is high for exactly one cycle, coincident with Out showing the post-wrap index.

## Test plan
- Reset: hold rst=1 with default params → Out=8'h00, Index=0, Wrap=0. Assert rst asynchronously mid-scan → outputs clear before the next clka edge.
- Direct decode: E=1, Mode=0, Load=1, In=0..7 on successive cycles → Out=8'h01, 02, 04, …, 80, each one cycle after its In. Then E=0 → Out=8'h00 with Index held at 7.
- Scan up, PERIOD=2: load In=6, then Mode=1, Dir=0 → Index 6,6,7,7,0,0,1… Wrap=1 only on the cycle Index becomes 0. Out=8'h01 on that cycle.
- Scan down, PERIOD=1: load In=1, Dir=1 → Index 0,7,6… Wrap pulses exactly once, when Index becomes 7. Out=8'h80 on that cycle.
- Load mid-scan on a step cycle (PERIOD=3, In=4) → Index=4, no step, Wrap=0. Next step occurs 3 cycles later, to 5.
- ACTIVE_LOW=1, N=2, direct In=2 → Out=4'b1011. With E=0 → Out=4'b1111.

Source files
------------

// File: rtl/decoder_n_scan.sv
// decoder_n_scan
//   Registered N-to-2^N one-hot (or one-cold) decoder with a self-stepping
//   scan mode. In direct mode it decodes the held/loaded index; in scan mode
//   the index advances up or down every PERIOD cycles, with a one-cycle Wrap
//   pulse on each wrap-around.
//
// Ports
//   clka   : clock, all state updates on the rising edge
//   rst    : asynchronous active-high reset
//   E      : enable; low forces Out inactive and freezes the index
//   Mode   : 0 direct decode, 1 scan
//   Dir    : scan direction, 0 up, 1 down
//   Load   : load In into the index (either mode)
//   In     : index to load
//   Out    : registered select, exactly one bit active when E was high
//   Index  : current index register
//   Wrap   : one-cycle pulse coincident with the post-wrap index on Out
module decoder_n_scan #(
  parameter int N          = 3,
  parameter int PERIOD     = 1,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                clka,
  input  logic                rst,
  input  logic                E,
  input  logic                Mode,
  input  logic                Dir,
  input  logic                Load,
  input  logic [N-1:0]        In,
  output logic [(1<<N)-1:0]   Out,
  output logic [N-1:0]        Index,
  output logic                Wrap
);

  localparam int OW = 1 << N;
  // Keep the prescaler at least one bit wide; with PERIOD=1 it never leaves 0
  // and every scan cycle is a step cycle.
  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(PERIOD - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [N-1:0]  IDX_ONE    = N'(1);
  localparam logic [N-1:0]  IDX_MAX    = '1;

  function automatic logic [OW-1:0] inactive_pattern();
    return (ACTIVE_LOW != 0) ? {OW{1'b1}} : {OW{1'b0}};
  endfunction

  function automatic logic [OW-1:0] select_pattern(input logic [N-1:0] k);
    logic [OW-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return (ACTIVE_LOW != 0) ? ~v : v;
  endfunction

  logic [N-1:0]  idx_p0,   idx_nxt;
  logic [PW-1:0] presc_p0, presc_nxt;
  logic [OW-1:0] out_p0,   out_nxt;
  logic          wrap_p0,  wrap_nxt;

  // Next-state selection, in priority order: disable, load, direct, scan
  // count, scan step.
  always_comb begin
    idx_nxt   = idx_p0;
    presc_nxt = '0;
    out_nxt   = inactive_pattern();
    wrap_nxt  = 1'b0;
    if (!E) begin
      idx_nxt = idx_p0;
    end else if (Load) begin
      idx_nxt = In;
      out_nxt = select_pattern(In);
    end else if (!Mode) begin
      out_nxt = select_pattern(idx_p0);
    end else if (presc_p0 != PRESC_LAST) begin
      presc_nxt = presc_p0 + PRESC_ONE;
      out_nxt   = select_pattern(idx_p0);
    end else begin
      idx_nxt  = Dir ? (idx_p0 - IDX_ONE) : (idx_p0 + IDX_ONE);
      out_nxt  = select_pattern(idx_nxt);
      wrap_nxt = Dir ? (idx_p0 == '0) : (idx_p0 == IDX_MAX);
    end
  end

  // Stage p0: output register
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      idx_p0   <= '0;
      presc_p0 <= '0;
      out_p0   <= inactive_pattern();
      wrap_p0  <= 1'b0;
    end else begin
      idx_p0   <= idx_nxt;
      presc_p0 <= presc_nxt;
      out_p0   <= out_nxt;
      wrap_p0  <= wrap_nxt;
    end
  end

  assign Out   = out_p0;
  assign Index = idx_p0;
  assign Wrap  = wrap_p0;

endmodule
